// File: rtl/current_offset_corrector.sv
// current_offset_corrector
//   Front end of the motor-current path. Calibrates a per-channel zero-current
//   offset by averaging 2**AVG_SHIFT raw ADC beats (round half up). It then
//   streams signed, offset-removed, gain-shifted and saturated samples over
//   Avalon-ST through a single registered output stage.
//   Channel i occupies bits [i*W +: W] of every packed bus.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   calib_start  request recalibration (level, honoured only in RUN)
//   calib_busy   1 while calibrating
//   offset_out   current per-channel offsets (unsigned, ADC_WIDTH each)
//   in_data      raw unsigned ADC codes (ADC_WIDTH each)
//   in_valid     sink valid
//   in_ready     sink ready
//   out_data     corrected signed samples (DATA_WIDTH each)
//   out_valid    source valid
//   out_ready    source ready
module current_offset_corrector #(
   parameter int ADC_WIDTH  = 12,
   parameter int DATA_WIDTH = 16,
   parameter int DATA_COUNT = 1,
   parameter int AVG_SHIFT  = 6,
   parameter int GAIN_SHIFT = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             calib_start,
   output logic                             calib_busy,
   output logic [DATA_COUNT*ADC_WIDTH-1:0]  offset_out,
   input  logic [DATA_COUNT*ADC_WIDTH-1:0]  in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   output logic [DATA_COUNT*DATA_WIDTH-1:0] out_data,
   output logic                             out_valid,
   input  logic                             out_ready
);

   localparam int ACC_W = ADC_WIDTH + AVG_SHIFT;
   localparam int SW    = ADC_WIDTH + 1 + GAIN_SHIFT;
   // Working width for saturation: wide enough for both the shifted
   // difference and the output range, plus one guard bit.
   localparam int WW    = ((SW > DATA_WIDTH) ? SW : DATA_WIDTH) + 1;

   localparam logic [ACC_W-1:0]      HALF    = ACC_W'(1) << (AVG_SHIFT - 1);
   localparam logic [ADC_WIDTH-1:0]  MID     = ADC_WIDTH'(1) << (ADC_WIDTH - 1);
   localparam logic signed [WW-1:0]  MAX_EXT = {{(WW-DATA_WIDTH){1'b0}}, 1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [WW-1:0]  MIN_EXT = {{(WW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {
      ST_CALIB,
      ST_RUN
   } state_t;

   state_t                           state_q, state_d;
   logic [ACC_W-1:0]                 acc_q [DATA_COUNT];
   logic [ACC_W-1:0]                 acc_d [DATA_COUNT];
   logic [AVG_SHIFT-1:0]             cnt_q, cnt_d;
   logic [DATA_COUNT*ADC_WIDTH-1:0]  offset_q, offset_d;
   logic [DATA_COUNT*DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                             out_valid_q, out_valid_d;

   logic signed [ADC_WIDTH:0]        d_c   [DATA_COUNT];
   logic signed [WW-1:0]             s_c   [DATA_COUNT];
   logic [ACC_W-1:0]                 sum_c [DATA_COUNT];
   logic [DATA_COUNT*DATA_WIDTH-1:0] y_c;
   logic [DATA_COUNT*ADC_WIDTH-1:0]  avg_c;
   logic                             beat;

   assign calib_busy = (state_q == ST_CALIB);
   assign offset_out = offset_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign in_ready   = (state_q == ST_CALIB) | ~out_valid_q | out_ready;
   assign beat       = in_valid & in_ready;

   // Datapath: corrected samples and the rounded averages for the closing beat.
   always_comb begin
      y_c   = '0;
      avg_c = '0;
      for (int unsigned i = 0; i < DATA_COUNT; i++) begin
         d_c[i] = $signed({1'b0, in_data[i*ADC_WIDTH +: ADC_WIDTH]})
                - $signed({1'b0, offset_q[i*ADC_WIDTH +: ADC_WIDTH]});
         s_c[i] = $signed({{(WW-ADC_WIDTH-1){d_c[i][ADC_WIDTH]}}, d_c[i]}) <<< GAIN_SHIFT;
         if (s_c[i] > MAX_EXT) begin
            y_c[i*DATA_WIDTH +: DATA_WIDTH] = MAX_EXT[DATA_WIDTH-1:0];
         end else if (s_c[i] < MIN_EXT) begin
            y_c[i*DATA_WIDTH +: DATA_WIDTH] = MIN_EXT[DATA_WIDTH-1:0];
         end else begin
            y_c[i*DATA_WIDTH +: DATA_WIDTH] = s_c[i][DATA_WIDTH-1:0];
         end
         // Cannot overflow: max is (2**S)*(2**A-1) + 2**(S-1) < 2**(A+S).
         sum_c[i] = acc_q[i] + ACC_W'(in_data[i*ADC_WIDTH +: ADC_WIDTH]) + HALF;
         avg_c[i*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(sum_c[i] >> AVG_SHIFT);
      end
   end

   // Control: next state, accumulators, offsets and output stage.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      offset_d    = offset_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      for (int unsigned i = 0; i < DATA_COUNT; i++) begin
         acc_d[i] = acc_q[i];
      end

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_CALIB: begin
            if (beat) begin
               cnt_d = cnt_q + 1'b1;
               for (int unsigned i = 0; i < DATA_COUNT; i++) begin
                  acc_d[i] = acc_q[i] + ACC_W'(in_data[i*ADC_WIDTH +: ADC_WIDTH]);
               end
               // Last beat of the window: the counter wraps to zero by itself.
               if (cnt_q == '1) begin
                  offset_d = avg_c;
                  state_d  = ST_RUN;
                  for (int unsigned i = 0; i < DATA_COUNT; i++) begin
                     acc_d[i] = '0;
                  end
               end
            end
         end
         ST_RUN: begin
            if (beat) begin
               out_valid_d = 1'b1;
               out_data_d  = y_c;
            end
            if (calib_start) begin
               state_d = ST_CALIB;
               cnt_d   = '0;
               for (int unsigned i = 0; i < DATA_COUNT; i++) begin
                  acc_d[i] = '0;
               end
            end
         end
         default: state_d = ST_CALIB;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_CALIB;
         cnt_q       <= '0;
         offset_q    <= {DATA_COUNT{MID}};
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         for (int unsigned i = 0; i < DATA_COUNT; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         offset_q    <= offset_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         for (int unsigned i = 0; i < DATA_COUNT; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

endmodule
